// File: rtl/seg_pkg.sv
// Shared constants for the BCD seven-segment scanner: segment patterns
// (active-low {g,f,e,d,c,b,a}), blanking values and the digit-slot enum.
package seg_pkg;

    localparam int PRESC_W = 16;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic       DP_OFF  = 1'b1;

    typedef enum logic [1:0] {
        DIG0,
        DIG1,
        DIG2,
        DIG3
    } digit_idx_e;

    // One-hot-low anode pattern for the given digit slot.
    function automatic logic [3:0] anode_for(digit_idx_e idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_seg_scanner_if.sv
// Display-side bundle of the scanner: BCD/decimal-point inputs, blanking
// control and the multiplexed anode/segment outputs.
interface bcd_seg_scanner_if;

    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        scan_tick;

    modport master (
        output digits, dp_in, blank,
        input  an, seg, dp, scan_tick
    );

    modport slave (
        input  digits, dp_in, blank,
        output an, seg, dp, scan_tick
    );

endinterface

// File: rtl/bcd_seg_scanner_core.sv
// Scanner engine: prescaler, digit index, tear-free shadow and registered
// display outputs. BCD_SEG_LEADING_ZERO_BLANK_EN darkens leading zeros.
module bcd_seg_scanner_core
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 4
)
(
    input logic              clk,
    input logic              clr,
    bcd_seg_scanner_if.slave bus
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

    logic [PRESC_W-1:0] presc;
    digit_idx_e         idx;
    logic               running;
    logic [15:0]        shadow_digits;
    logic [3:0]         shadow_dp;
    logic               tick;
    logic [3:0]         sel_value;
    logic [6:0]         sel_pattern;
    logic               sel_lit;
    logic [3:0]         an_q;
    logic [6:0]         seg_q;
    logic               dp_q;

    // running stays low for the single cycle after reset release, which is
    // spent loading the shadow so the first lit digit already has valid data.
    assign tick = running && (presc == PRESC_LAST);

    always_comb begin
        sel_value = shadow_digits[3:0];
        case (idx)
            DIG1:    sel_value = shadow_digits[7:4];
            DIG2:    sel_value = shadow_digits[11:8];
            DIG3:    sel_value = shadow_digits[15:12];
            default: sel_value = shadow_digits[3:0];
        endcase
    end

`ifdef BCD_SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        sel_lit = 1'b1;
        case (idx)
            DIG3:    sel_lit = (shadow_digits[15:12] != 4'd0);
            DIG2:    sel_lit = (shadow_digits[15:8]  != 8'd0);
            DIG1:    sel_lit = (shadow_digits[15:4]  != 12'd0);
            default: sel_lit = 1'b1;
        endcase
    end
`else
    assign sel_lit = 1'b1;
`endif

    bcd_to_seg u_dec (
        .value   (sel_value),
        .pattern (sel_pattern)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc         <= '0;
            idx           <= DIG0;
            running       <= 1'b0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= DP_OFF;
        end else if (!running) begin
            running       <= 1'b1;
            shadow_digits <= bus.digits;
            shadow_dp     <= bus.dp_in;
        end else begin
            presc <= tick ? '0 : presc + PRESC_W'(1);
            if (tick) begin
                idx <= digit_idx_e'(idx + 2'd1);
                // Re-sample only at the scan boundary so one scan never mixes two counts.
                if (idx == DIG3) begin
                    shadow_digits <= bus.digits;
                    shadow_dp     <= bus.dp_in;
                end
            end
            if (bus.blank || !sel_lit) begin
                an_q  <= AN_OFF;
                seg_q <= SEG_OFF;
                dp_q  <= DP_OFF;
            end else begin
                an_q  <= anode_for(idx);
                seg_q <= sel_pattern;
                dp_q  <= ~shadow_dp[idx];
            end
        end
    end

    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.scan_tick = tick;

endmodule

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15
// render as a dash so a corrupted counter is visible on the display.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (value)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Four-digit multiplexed BCD seven-segment display driver (top level).
// Optional leading-zero blanking via BCD_SEG_LEADING_ZERO_BLANK_EN.
module bcd_seg_scanner #(
    parameter int SCAN_DIV = 4
)
(
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        scan_tick
);

    bcd_seg_scanner_if bus ();

    assign bus.digits = digits;
    assign bus.dp_in  = dp_in;
    assign bus.blank  = blank;
    assign an         = bus.an;
    assign seg        = bus.seg;
    assign dp         = bus.dp;
    assign scan_tick  = bus.scan_tick;

    bcd_seg_scanner_core #(
        .SCAN_DIV (SCAN_DIV)
    ) u_core (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Self-checking bench for bcd_seg_scanner: directed scenarios plus random
// traffic against a time-based display model (honours BCD_SEG_LEADING_ZERO_BLANK_EN).
module tb_bcd_seg_scanner;

    localparam int D = 4;

    logic clk = 1'b0;
    logic clr;

    bcd_seg_scanner_if bus ();

    bcd_seg_scanner #(
        .SCAN_DIV (D)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .digits    (bus.digits),
        .dp_in     (bus.dp_in),
        .blank     (bus.blank),
        .an        (bus.an),
        .seg       (bus.seg),
        .dp        (bus.dp),
        .scan_tick (bus.scan_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: edges counted since reset release, plus the scan snapshot.
    int         edge_n = 0;
    logic [3:0] m_dig [4];
    logic [3:0] m_dp;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_tick;
    logic [6:0] seg_ref [16];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpv, input logic blk);
        bus.digits = d;
        bus.dp_in  = dpv;
        bus.blank  = blk;
    endtask

    function automatic logic digitLit(input int pos);
        int upper;
        upper = 0;
        for (int k = pos; k < 4; k++) upper = upper * 16 + int'(m_dig[k]);
`ifdef BCD_SEG_LEADING_ZERO_BLANK_EN
        return (pos == 0) || (upper != 0);
`else
        return 1'b1;
`endif
    endfunction

    task automatic modelOff();
        exp_an   = 4'hF;
        exp_seg  = 7'h7F;
        exp_dp   = 1'b1;
        exp_tick = 1'b0;
    endtask

    task automatic modelReset();
        edge_n = 0;
        for (int k = 0; k < 4; k++) m_dig[k] = 4'd0;
        m_dp = 4'd0;
        modelOff();
    endtask

    // Each slot lasts D edges; the first lit slot starts at edge 2 and a
    // fresh snapshot is taken at edge 1 and every 4*D edges thereafter.
    task automatic modelEdge();
        int slot;
        int pos;
        edge_n++;
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
        if (edge_n >= 2) begin
            slot = (edge_n - 2) / D;
            pos  = slot % 4;
            if (!bus.blank && digitLit(pos)) begin
                exp_an[pos] = 1'b0;
                exp_seg     = seg_ref[m_dig[pos]];
                exp_dp      = ~m_dp[pos];
            end
        end
        if ((edge_n - 1) % (4 * D) == 0) begin
            for (int k = 0; k < 4; k++) m_dig[k] = bus.digits[k*4 +: 4];
            m_dp = bus.dp_in;
        end
        exp_tick = ((edge_n - 1) % D) == (D - 1);
    endtask

    task automatic runCycle();
        @(posedge clk);
        if (clr) modelEdge();
        else     modelOff();
        @(negedge clk);
        checkOutput("an",   32'(bus.an),        32'(exp_an));
        checkOutput("seg",  32'(bus.seg),       32'(exp_seg));
        checkOutput("dp",   32'(bus.dp),        32'(exp_dp));
        checkOutput("tick", 32'(bus.scan_tick), 32'(exp_tick));
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) runCycle();
    endtask

    function automatic int curPos();
        return ((edge_n - 2) / D) % 4;
    endfunction

    initial begin
        int found;
        int ticks;

        seg_ref[0] = 7'b1000000;  seg_ref[1] = 7'b1111001;
        seg_ref[2] = 7'b0100100;  seg_ref[3] = 7'b0110000;
        seg_ref[4] = 7'b0011001;  seg_ref[5] = 7'b0010010;
        seg_ref[6] = 7'b0000010;  seg_ref[7] = 7'b1111000;
        seg_ref[8] = 7'b0000000;  seg_ref[9] = 7'b0010000;
        for (int v = 10; v < 16; v++) seg_ref[v] = 7'b0111111;

        clr = 1'b0;
        applyStimulus(16'h1234, 4'b0000, 1'b0);
        modelReset();
        $display("[TB] reset state");
        runCycles(3);

        // Basic scan of 1234; first lit digit must appear on the second edge.
        @(negedge clk);
        #1 clr = 1'b1;
        modelReset();
        runCycle();
        checkOutput("first_edge_an", 32'(bus.an), 32'h0000000F);
        runCycle();
        checkOutput("second_edge_an",  32'(bus.an),  32'h0000000E);
        checkOutput("second_edge_seg", 32'(bus.seg), 32'h00000019);
        runCycles(4 * D * 2);

        // Change the inputs mid-scan while digit1 is showing.
        $display("[TB] no-tearing scenario");
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (edge_n >= 2 && curPos() == 1) found = 1;
            else runCycle();
        end
        checkOutput("idx1_wait", 32'(found), 32'd1);
        applyStimulus(16'h5678, 4'b0000, 1'b0);
        runCycles(4 * D * 2);

        $display("[TB] dash and decimal point");
        applyStimulus(16'h00A5, 4'b1010, 1'b0);
        runCycles(4 * D * 2 + 2);

        $display("[TB] leading zeros");
        applyStimulus(16'h0007, 4'b0000, 1'b0);
        runCycles(4 * D * 2 + 2);

        // Asynchronous reset in the middle of the digit2 slot.
        $display("[TB] mid-slot reset");
        applyStimulus(16'h4321, 4'b0100, 1'b0);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (edge_n >= 2 && curPos() == 2 && ((edge_n - 2) % D) == 1) found = 1;
            else runCycle();
        end
        checkOutput("idx2_wait", 32'(found), 32'd1);
        #1 clr = 1'b0;
        #1;
        checkOutput("async_an",   32'(bus.an),        32'h0000000F);
        checkOutput("async_seg",  32'(bus.seg),       32'h0000007F);
        checkOutput("async_dp",   32'(bus.dp),        32'd1);
        checkOutput("async_tick", 32'(bus.scan_tick), 32'd0);
        modelReset();
        runCycles(2);
        @(negedge clk);
        #1 clr = 1'b1;
        modelReset();
        runCycle();
        checkOutput("rel_first_an", 32'(bus.an), 32'h0000000F);
        runCycle();
        checkOutput("rel_second_an", 32'(bus.an), 32'h0000000E);
        runCycles(4 * D);

        $display("[TB] blanking");
        applyStimulus(16'h9876, 4'b0001, 1'b1);
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            runCycle();
            if (bus.scan_tick) ticks++;
        end
        checkOutput("blank_ticks", 32'(ticks >= 2), 32'd1);
        applyStimulus(16'h9876, 4'b0001, 1'b0);
        runCycles(4 * D * 2);

        $display("[TB] random traffic");
        for (int r = 0; r < 40; r++) begin
            applyStimulus(16'($urandom), 4'($urandom_range(0, 15)),
                          $urandom_range(0, 7) == 0);
            runCycles(int'($urandom_range(1, 20)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
